// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer_if
//  Description : Bundle of the store-buffer ports: enqueue from the memory
//                stage, load lookup, drain to the data cache and occupancy.
//  Revision    : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Enqueue (memory stage -> buffer)
  logic              enq_valid;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic              enq_byte;
  logic              enq_ready;

  // Load lookup
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              ld_partial;

  // Drain (buffer -> data cache)
  logic              drain_req;
  logic [ADDR_W-1:0] drain_addr;
  logic [DATA_W-1:0] drain_data;
  logic              drain_byte;
  logic              drain_ack;

  // Occupancy
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  // Environment side: memory stage plus data cache
  modport master (
    output enq_valid, enq_addr, enq_data, enq_byte,
    input  enq_ready,
    output ld_valid, ld_addr,
    input  ld_hit, ld_data, ld_partial,
    input  drain_req, drain_addr, drain_data, drain_byte,
    output drain_ack,
    input  count, empty, full
  );

  // Buffer side
  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_byte,
    output enq_ready,
    input  ld_valid, ld_addr,
    output ld_hit, ld_data, ld_partial,
    output drain_req, drain_addr, drain_data, drain_byte,
    input  drain_ack,
    output count, empty, full
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : store_buffer
//  Description : Committed-store FIFO between the memory stage and the data
//                cache. Drains in program order, forwards word-store data to
//                matching loads and flags byte-store matches as partial hits.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry storage; only the valid bits carry reset
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  byte_q;
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [PTR_W-1:0]  hd_q, hd_d;
  logic [PTR_W-1:0]  tl_q, tl_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full;
  logic              empty;
  logic              enq_fire;
  logic              deq_fire;

  // Status comes from registered count only, so a same-cycle drain_ack
  // cannot open a slot for a same-cycle enqueue while full.
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign enq_fire = bus.enq_valid & ~full;
  assign deq_fire = valid_q[hd_q] & bus.drain_ack;

  // Next-state for pointers, occupancy and valid bits
  always_comb begin
    hd_d    = hd_q;
    tl_d    = tl_q;
    count_d = count_q;
    valid_d = valid_q;
    if (deq_fire) begin
      valid_d[hd_q] = 1'b0;
      hd_d          = hd_q + PTR_W'(1);
    end
    if (enq_fire) begin
      valid_d[tl_q] = 1'b1;
      tl_d          = tl_q + PTR_W'(1);
    end
    if (enq_fire && !deq_fire) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq_fire && deq_fire) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hd_q    <= '0;
      tl_q    <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      hd_q    <= hd_d;
      tl_q    <= tl_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload write at the tail on an accepted store
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      addr_q[tl_q] <= bus.enq_addr;
      data_q[tl_q] <= bus.enq_data;
      byte_q[tl_q] <= bus.enq_byte;
    end
  end

  // Head presentation; payload is masked when the head slot is empty so the
  // outputs read zero after reset regardless of stale storage.
  assign bus.drain_req  = valid_q[hd_q];
  assign bus.drain_addr = valid_q[hd_q] ? addr_q[hd_q] : '0;
  assign bus.drain_data = valid_q[hd_q] ? data_q[hd_q] : '0;
  assign bus.drain_byte = valid_q[hd_q] & byte_q[hd_q];

  assign bus.enq_ready  = ~full;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count_q;

  logic [PTR_W-1:0]  age_idx;
  logic              lk_match;
  logic              lk_byte;
  logic [DATA_W-1:0] lk_data;

  // Walk entries oldest to youngest from the head; the last match seen is
  // the youngest store to that word. Valid entries are contiguous from hd.
  always_comb begin
    lk_match = 1'b0;
    lk_byte  = 1'b0;
    lk_data  = '0;
    age_idx  = hd_q;
    for (int i = 0; i < DEPTH; i++) begin
      age_idx = hd_q + PTR_W'(i);
      if (valid_q[age_idx] &&
          (addr_q[age_idx][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2])) begin
        lk_match = 1'b1;
        lk_byte  = byte_q[age_idx];
        lk_data  = data_q[age_idx];
      end
    end
  end

  assign bus.ld_hit     = bus.ld_valid & lk_match & ~lk_byte;
  assign bus.ld_partial = bus.ld_valid & lk_match & lk_byte;
  assign bus.ld_data    = (bus.ld_valid & lk_match & ~lk_byte) ? lk_data : '0;

  // Byte offset of the load address is irrelevant at word granularity
  logic unused_ld_offset;
  assign unused_ld_offset = &{1'b0, bus.ld_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_store_buffer
//  Description : Scoreboard bench for store_buffer. A queue-based reference
//                model predicts every cycle's outputs; a monitor compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          bt;
  } ent_t;

  typedef struct {
    logic          enq_ready;
    logic [2:0]    count;
    logic          empty;
    logic          full;
    logic          drain_req;
    logic [AW-1:0] drain_addr;
    logic [DW-1:0] drain_data;
    logic          drain_byte;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          ld_partial;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) sbif ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sbif)
  );

  ent_t model [$];
  exp_t exp_q [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: the buffer is an ordered list of pending stores, oldest first
  function automatic exp_t predict(bit lv, logic [AW-1:0] la);
    exp_t e;
    int   n;
    n            = model.size();
    e.count      = 3'(n);
    e.empty      = (n == 0);
    e.full       = (n == DEPTH);
    e.enq_ready  = (n != DEPTH);
    e.drain_req  = (n > 0);
    e.drain_addr = (n > 0) ? model[0].addr : '0;
    e.drain_data = (n > 0) ? model[0].data : '0;
    e.drain_byte = (n > 0) ? model[0].bt : 1'b0;
    e.ld_hit     = 1'b0;
    e.ld_partial = 1'b0;
    e.ld_data    = '0;
    if (lv) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (model[i].addr[AW-1:2] == la[AW-1:2]) begin
          if (model[i].bt) e.ld_partial = 1'b1;
          else begin
            e.ld_hit  = 1'b1;
            e.ld_data = model[i].data;
          end
          break;
        end
      end
    end
    return e;
  endfunction

  // One clock of stimulus: drive, record expectation, advance the model
  task automatic cycle(input bit r, input bit ev, input logic [31:0] ea,
                       input logic [31:0] ed, input bit eb, input bit ack,
                       input bit lv, input logic [31:0] la);
    ent_t ne;
    bit   do_enq;
    bit   do_deq;
    @(posedge clk);
    #1;
    rst            = r;
    sbif.enq_valid = ev;
    sbif.enq_addr  = ea;
    sbif.enq_data  = ed;
    sbif.enq_byte  = eb;
    sbif.drain_ack = ack;
    sbif.ld_valid  = lv;
    sbif.ld_addr   = la;
    exp_q.push_back(predict(lv, la));
    if (r) begin
      model.delete();
    end else begin
      do_enq = ev && (model.size() < DEPTH);
      do_deq = ack && (model.size() > 0);
      if (do_deq) void'(model.pop_front());
      if (do_enq) begin
        ne.addr = ea;
        ne.data = ed;
        ne.bt   = eb;
        model.push_back(ne);
      end
    end
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d, input bit b);
    cycle(0, 1, a, d, b, 0, 0, 0);
  endtask

  task automatic idle(input bit ack, input bit lv, input logic [31:0] la);
    cycle(0, 0, 0, 0, 0, ack, lv, la);
  endtask

  // Monitor: compare DUT outputs against the oldest pending expectation
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("enq_ready",  32'(sbif.enq_ready),  32'(e.enq_ready));
        chk("count",      32'(sbif.count),      32'(e.count));
        chk("empty",      32'(sbif.empty),      32'(e.empty));
        chk("full",       32'(sbif.full),       32'(e.full));
        chk("drain_req",  32'(sbif.drain_req),  32'(e.drain_req));
        chk("drain_addr", sbif.drain_addr,      e.drain_addr);
        chk("drain_data", sbif.drain_data,      e.drain_data);
        chk("drain_byte", 32'(sbif.drain_byte), 32'(e.drain_byte));
        chk("ld_hit",     32'(sbif.ld_hit),     32'(e.ld_hit));
        chk("ld_data",    sbif.ld_data,         e.ld_data);
        chk("ld_partial", 32'(sbif.ld_partial), 32'(e.ld_partial));
      end
    end
  end

  initial begin
    sbif.enq_valid = 1'b0;
    sbif.enq_addr  = '0;
    sbif.enq_data  = '0;
    sbif.enq_byte  = 1'b0;
    sbif.drain_ack = 1'b0;
    sbif.ld_valid  = 1'b0;
    sbif.ld_addr   = '0;
    rst            = 1'b1;
    repeat (2) @(posedge clk);

    // Reset values, then an idle load
    idle(0, 0, 0);
    idle(0, 1, 32'h100);

    // Fill to full, refuse a fifth store (with ack asserted), then drain
    enq(32'h10, 32'h1000_0010, 0);
    enq(32'h14, 32'h1000_0014, 0);
    enq(32'h18, 32'h1000_0018, 0);
    enq(32'h1C, 32'h1000_001C, 0);
    cycle(0, 1, 32'h20, 32'hDEAD_0020, 0, 1, 0, 0);
    repeat (4) idle(1, 0, 0);
    idle(0, 0, 0);

    // Youngest word store wins
    enq(32'h40, 32'hAAAA_AAAA, 0);
    enq(32'h40, 32'hBBBB_BBBB, 0);
    idle(0, 1, 32'h42);
    idle(0, 1, 32'h44);
    idle(1, 1, 32'h40);
    idle(1, 1, 32'h40);
    idle(0, 1, 32'h40);

    // Byte store after a word store to the same word gives a partial hit
    enq(32'h80, 32'h1111_1111, 0);
    enq(32'h81, 32'h0000_0022, 1);
    idle(0, 1, 32'h80);
    idle(1, 1, 32'h80);
    idle(1, 1, 32'h80);
    idle(0, 1, 32'h80);

    // Simultaneous enqueue and drain at count 1, pointers wrap
    enq(32'h300, 32'h0000_0300, 0);
    for (int i = 1; i <= 6; i++)
      cycle(0, 1, 32'h300 + 32'(i * 4), 32'h0000_0300 + 32'(i), 0, 1, 0, 0);
    idle(1, 0, 0);
    idle(0, 0, 0);

    // Reset with three stores pending
    enq(32'h200, 32'h0000_0200, 0);
    enq(32'h204, 32'h0000_0204, 0);
    enq(32'h208, 32'h0000_0208, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 32'h204);
    idle(0, 1, 32'h200);
    idle(0, 1, 32'h204);
    idle(0, 1, 32'h208);

    // Randomized traffic over a small address window to force matches
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 60) == 0,
            $urandom_range(0, 2) != 0,
            32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)),
            32'($urandom),
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0,
            32'h100 + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3)));
    end
    idle(0, 0, 0);

    // Let the monitor consume the remaining expectations, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL monitor_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/store_buffer.md
# store_buffer

Committed-store buffer sitting directly downstream of the memory stage, between it and the data-cache port. Stores leaving the memory stage are enqueued in one cycle instead of waiting on the cache; the buffer drains them in program order through a request/acknowledge port. Loads in the memory stage search the buffer each cycle: a word-store match forwards data, a byte-store match reports a partial hit so the memory stage stalls.

## Interface

- DEPTH, 4: number of entries; power of two, at least 2.
- ADDR_W, 32: address width (ARCH_LEN).
- DATA_W, 32: data width (ARCH_LEN).

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- enq_valid  in  1  memory stage presents a committed store.
- enq_addr  in  ADDR_W  store byte address.
- enq_data  in  DATA_W  store data; only [7:0] is meaningful for byte stores.
- enq_byte  in  1  1 = byte store, 0 = word store.
- enq_ready  out  1  equals !full; the store is accepted when enq_valid & enq_ready.
- ld_valid  in  1  memory stage presents a load for lookup.
- ld_addr  in  ADDR_W  load address; word granularity, compared on [ADDR_W-1:2].
- ld_hit  out  1  youngest matching entry is a word store; forward ld_data.
- ld_data  out  DATA_W  data of the youngest matching word store, else 0.
- ld_partial  out  1  youngest matching entry is a byte store; the load must stall.
- drain_req  out  1  head entry is valid and presented to the cache.
- drain_addr  out  ADDR_W  head address.
- drain_data  out  DATA_W  head data.
- drain_byte  out  1  head size.
- drain_ack  in  1  cache accepted the head this cycle; ignored when drain_req=0.
- count  out  $clog2(DEPTH+1)  occupied entries.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.

## Operation

- Storage is a circular FIFO of {addr, data, byte, valid} entries.
  - Head pointer hd and tail pointer tl, each $clog2(DEPTH) bits, wrap naturally at DEPTH.
  - count is kept as a separate register.
- Enqueue: when enq_valid & !full, write the entry at tl, set its valid bit, tl←tl+1.
- Enqueue while full is refused: enq_ready=0, and the buffer state does not change.
  - A drain_ack in the same cycle as a full buffer does not open a slot that cycle. The slot opens the following cycle.
- Drain: drain_req = valid[hd]. drain_* are driven directly from entry hd.
  - On drain_req & drain_ack: clear valid[hd], hd←hd+1.
- Simultaneous accepted enqueue and drain: count is unchanged, and both pointers advance.
  - When count==1, the enqueued entry becomes the head after the popped entry leaves.
- count update: +1 on enqueue only, −1 on drain only, unchanged on both or neither.
- Load lookup is combinational over registered state only. A store enqueued in the same cycle is not visible.
  - Search all valid entries from youngest (tl−1) to oldest (hd).
  - An entry matches when entry.addr[ADDR_W-1:2]==ld_addr[ADDR_W-1:2].
  - If the youngest match is a word store: ld_hit=1, ld_data=entry.data, ld_partial=0.
  - If the youngest match is a byte store: ld_partial=1, ld_hit=0, ld_data=0.
  - If there is no match or ld_valid=0: ld_hit=0, ld_partial=0, ld_data=0.
- Reset clears hd, tl, count and all valid bits.
  - Any drain in flight is abandoned; the cache must also be reset.

## Timing

- Reset values: enq_ready=1, ld_hit=0, ld_data=0, ld_partial=0, drain_req=0, drain_addr=0, drain_data=0, drain_byte=0, count=0, empty=1, full=0.
- Enqueue to drain_req: 1 cycle. A store accepted at edge N is presented at the head in cycle N+1 if the buffer was empty.
- Enqueue to lookup visibility: 1 cycle.
- Drain_ack to next head: the following cycle presents entry hd+1. Back-to-back acks drain one entry per cycle.
- enq_ready, full, empty and count are registered-state derived. They do not depend on same-cycle enq_valid or drain_ack.
- Lookup outputs are combinational from ld_valid and ld_addr within the same cycle.
- Lookup outputs reflect the state before this cycle's enqueue or drain.

## Test plan

- Reset then idle: assert rst for 2 cycles → all outputs hold their reset values; a load to 0x100 gives ld_hit=0, ld_partial=0.
- Fill and overflow, DEPTH=4: enqueue word stores to 0x10, 0x14, 0x18, 0x1C, with drain_ack=0 → full=1, count=4, enq_ready=0.
  - A fifth store to 0x20 is refused.
  - Hold drain_ack=1 → heads 0x10, 0x14, 0x18, 0x1C are presented on consecutive cycles, then empty=1.
- Forwarding youngest-wins: enqueue word 0x40←0xAAAA_AAAA, then word 0x40←0xBBBB_BBBB.
  - A load at 0x42 gives ld_hit=1, ld_data=0xBBBB_BBBB.
  - A load at 0x44 gives no hit.
- Partial hit: enqueue word 0x80←0x1111_1111, then byte 0x81←0x22.
  - A load at 0x80 gives ld_partial=1, ld_hit=0.
  - After both entries drain, the same load gives ld_partial=0, ld_hit=0.
- Simultaneous enqueue and drain at count=1 with pointers wrapping past DEPTH−1 → count stays 1; the new entry is presented the next cycle with the correct addr and data.
- Reset mid-operation: with count=3 and drain_req=1, assert rst for 1 cycle → count=0, drain_req=0; a load to any previously stored address misses.
